// File: rtl/uart_rx_os16.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_os16
// Purpose  : 8N1 UART receiver, 16x oversampled with 2-of-3 majority voting
// Revision : 1.0
// ============================================================================
module uart_rx_os16 #(
  parameter int unsigned DIV = 326
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_in,
  output logic [7:0] bus_out,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       rx_busy
);

  localparam logic [15:0] c_div_last = 16'(DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t      state_q;
  logic        s1_q, s2_q, s3_q;
  logic [15:0] cnt_q;
  logic [3:0]  sub_q;
  logic [2:0]  idx_q;
  logic [1:0]  samp_q;
  logic [7:0]  shreg_q;
  logic [7:0]  bus_q;
  logic        valid_q, err_q, busy_q;

  logic w_tick, w_start, w_maj;

  assign w_tick  = (cnt_q == c_div_last);
  assign w_start = (state_q == S_IDLE) && !s2_q && s3_q;
  // Third vote is the live synchronized sample taken on the sub-count 9 tick.
  assign w_maj   = (samp_q[0] & samp_q[1]) | (samp_q[0] & s2_q) | (samp_q[1] & s2_q);

  assign bus_out   = bus_q;
  assign rx_valid  = valid_q;
  assign frame_err = err_q;
  assign rx_busy   = busy_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      s1_q    <= 1'b1;
      s2_q    <= 1'b1;
      s3_q    <= 1'b1;
      cnt_q   <= '0;
      sub_q   <= '0;
      idx_q   <= '0;
      samp_q  <= '0;
      shreg_q <= '0;
      bus_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      s1_q    <= rx_in;
      s2_q    <= s1_q;
      s3_q    <= s2_q;
      valid_q <= 1'b0;
      err_q   <= 1'b0;

      if (state_q == S_IDLE) begin
        cnt_q <= '0;
        sub_q <= '0;
        idx_q <= '0;
        if (w_start) begin
          state_q <= S_START;
          busy_q  <= 1'b1;
        end
      end else begin
        cnt_q <= w_tick ? 16'd0 : cnt_q + 16'd1;
        if (w_tick) begin
          sub_q <= sub_q + 4'd1;
          if (sub_q == 4'd7) samp_q[0] <= s2_q;
          if (sub_q == 4'd8) samp_q[1] <= s2_q;

          case (state_q)
            S_START: begin
              if (sub_q == 4'd9 && w_maj) begin
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
              end else if (sub_q == 4'd15) begin
                state_q <= S_DATA;
                idx_q   <= '0;
              end
            end
            S_DATA: begin
              if (sub_q == 4'd9) shreg_q <= {w_maj, shreg_q[7:1]};
              if (sub_q == 4'd15) begin
                if (idx_q == 3'd7) state_q <= S_STOP;
                else               idx_q   <= idx_q + 3'd1;
              end
            end
            S_STOP: begin
              // Leave mid stop bit so an early next start edge is not missed.
              if (sub_q == 4'd9) begin
                if (w_maj) begin
                  bus_q   <= shreg_q;
                  valid_q <= 1'b1;
                end else begin
                  err_q   <= 1'b1;
                end
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
              end
            end
            default: state_q <= S_IDLE;
          endcase
        end
      end
    end
  end

endmodule
`default_nettype wire
